load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/lane_align.sv | 56 +++++
 rtl/load_store_unit.sv | 101 ++++++++++
 tb/tb_load_store_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 load/store width codes, LSU state encoding and request legality check.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    LOAD_RESP = 2'd2,
    WRITE     = 2'd3
  } lsu_state_t;

  // Unsigned widths exist only for loads; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] lane);
    logic ill;
    ill = 1'b0;
    case (f3)
      F3_B:    ill = 1'b0;
      F3_H:    ill = lane[0];
      F3_W:    ill = |lane;
      F3_BU:   ill = we;
      F3_HU:   ill = we | lane[0];
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane extraction/extension for loads and read-modify-write merge for stores.
module lane_align
  import riscv_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   lane,
  input  logic [n-1:0] ram_word,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] load_data,
  output logic [n-1:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = ram_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? ram_word[31:16] : ram_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = ram_word;
    endcase
  end

  // Each byte lane takes either the old RAM byte or the matching slice of wdata.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       hit;
    logic [7:0] src;

    always_comb begin
      case (funct3)
        F3_B: begin
          hit = (lane == LANE);
          src = wdata[7:0];
        end
        F3_H: begin
          hit = (lane[1] == LANE[1]);
          src = wdata[8*(gi%2) +: 8];
        end
        default: begin
          hit = 1'b1;
          src = wdata[8*gi +: 8];
        end
      endcase
    end

    assign store_data[8*gi +: 8] = hit ? src : ram_word[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a synchronous 32-bit word RAM.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         req,
  input  logic         we,
  input  logic [2:0]   funct3,
  input  logic [18:0]  addr,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] rdata,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         ramR,
  output logic         ramW,
  output logic [16:0]  ramAddr,
  output logic [n-1:0] ramDataW,
  input  logic [n-1:0] ramDataR
);

  lsu_state_t   state_q;
  logic         we_q;
  logic [2:0]   funct3_q;
  logic [18:0]  addr_q;
  logic [n-1:0] wdata_q;
  logic [n-1:0] rdata_q;
  logic         done_q;
  logic         err_q;
  logic [n-1:0] load_data;
  logic [n-1:0] store_data;
  logic         illegal;

  assign illegal = access_illegal(we, funct3, addr[1:0]);

  lane_align #(.n(n)) u_lane_align (
    .funct3     (funct3_q),
    .lane       (addr_q[1:0]),
    .ram_word   (ramDataR),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 19'd0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (illegal) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              we_q     <= we;
              funct3_q <= funct3;
              addr_q   <= addr;
              wdata_q  <= wdata;
              // Full-word stores skip the read; partial stores read-modify-write.
              state_q  <= (we && funct3 == F3_W) ? WRITE : READ;
            end
          end
        end
        READ:      state_q <= we_q ? WRITE : LOAD_RESP;
        LOAD_RESP: begin
          rdata_q <= load_data;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        WRITE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign ramR     = (state_q == READ);
  assign ramW     = (state_q == WRITE);
  assign ramAddr  = addr_q[18:2];
  assign ramDataW = ramW ? store_data : '0;
  assign rdata    = rdata_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: stimulus queues expected completions and writes, a monitor checks them.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clock  = 1'b0;
  logic        nReset = 1'b1;
  logic        req    = 1'b0;
  logic        we     = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [18:0] addr   = 19'd0;
  logic [31:0] wdata  = 32'd0;
  logic [31:0] rdata, ramDataW, ramDataR;
  logic        busy, done, err, ramR, ramW;
  logic [16:0] ramAddr;

  always #5 clock = ~clock;

  load_store_unit #(.n(32)) dut (
    .clock    (clock),
    .nReset   (nReset),
    .req      (req),
    .we       (we),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ramR     (ramR),
    .ramW     (ramW),
    .ramAddr  (ramAddr),
    .ramDataW (ramDataW),
    .ramDataR (ramDataR)
  );

  logic [31:0] mem [0:63];
  always @(posedge clock) begin
    if (ramR) ramDataR <= mem[ramAddr[5:0]];
    if (ramW) mem[ramAddr[5:0]] <= ramDataW;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          issue;
  } exp_t;

  typedef struct {
    logic [16:0] waddr;
    logic [31:0] wdat;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   ram_acts = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req_v);
    end
  endtask

  task automatic monitor();
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge clock);
      if (ramR || ramW) ram_acts++;
      if (ramW) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=addr %h data %h required=no write", ramAddr, ramDataW);
        end else begin
          w = wr_q.pop_front();
          check32("write_addr", {15'd0, ramAddr}, {15'd0, w.waddr});
          check32("write_data", ramDataW, w.wdat);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done required=idle");
        end else begin
          e = exp_q.pop_front();
          $display("TXN %s rdata=%h err=%b latency=%0d", e.name, rdata, err, cyc - e.issue);
          check32({e.name, "_rdata"}, rdata, e.rdata);
          check32({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
          check32({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
        end
      end
    end
  endtask

  task automatic access(input string nm, input logic w, input logic [2:0] f3,
                        input logic [18:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input logic exp_wr, input logic [31:0] exp_word);
    exp_t e;
    wr_t  wr;
    int   acts0;
    bit   seen;
    @(negedge clock);
    we = w; funct3 = f3; addr = a; wdata = d; req = 1'b1;
    e.name = nm; e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.issue = cyc;
    exp_q.push_back(e);
    if (exp_wr) begin
      wr.waddr = a[18:2];
      wr.wdat  = exp_word;
      wr_q.push_back(wr);
    end
    acts0 = ram_acts;
    @(negedge clock);
    req  = 1'b0;
    seen = done;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      seen = done;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no done required=done within 10 cycles", nm);
    end
    if (exp_err) check32({nm, "_no_ram"}, 32'(ram_acts - acts0), 32'd0);
  endtask

  initial begin
    exp_t e;
    fork
      monitor();
    join_none

    #2 nReset = 1'b0;
    #1;
    check32("reset_flags", {27'd0, busy, done, err, ramR, ramW}, 32'd0);
    check32("reset_rdata", rdata, 32'd0);
    repeat (2) @(negedge clock);
    nReset = 1'b1;

    access("sw_10",   1'b1, F3_W,   19'h00010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1'b1, 32'hDEADBEEF);
    access("lw_10",   1'b0, F3_W,   19'h00010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1'b0, 32'h0);
    access("sb_11",   1'b1, F3_B,   19'h00011, 32'h000000AA, 32'hDEADBEEF, 1'b0, 3, 1'b1, 32'hDEADAAEF);
    access("lb_11",   1'b0, F3_B,   19'h00011, 32'h0,        32'hFFFFFFAA, 1'b0, 3, 1'b0, 32'h0);
    access("lbu_11",  1'b0, F3_BU,  19'h00011, 32'h0,        32'h000000AA, 1'b0, 3, 1'b0, 32'h0);
    access("sh_12",   1'b1, F3_H,   19'h00012, 32'h00001234, 32'h000000AA, 1'b0, 3, 1'b1, 32'h1234AAEF);
    access("lh_12",   1'b0, F3_H,   19'h00012, 32'h0,        32'h00001234, 1'b0, 3, 1'b0, 32'h0);
    access("lhu_10",  1'b0, F3_HU,  19'h00010, 32'h0,        32'h0000AAEF, 1'b0, 3, 1'b0, 32'h0);
    access("lh_10",   1'b0, F3_H,   19'h00010, 32'h0,        32'hFFFFAAEF, 1'b0, 3, 1'b0, 32'h0);
    access("lw_13",   1'b0, F3_W,   19'h00013, 32'h0,        32'hFFFFAAEF, 1'b1, 1, 1'b0, 32'h0);
    access("ld_f011", 1'b0, 3'b011, 19'h00010, 32'h0,        32'hFFFFAAEF, 1'b1, 1, 1'b0, 32'h0);
    access("sh_11",   1'b1, F3_H,   19'h00011, 32'h5555,     32'hFFFFAAEF, 1'b1, 1, 1'b0, 32'h0);
    access("st_f100", 1'b1, F3_BU,  19'h00010, 32'h55,       32'hFFFFAAEF, 1'b1, 1, 1'b0, 32'h0);
    access("lb_13",   1'b0, F3_B,   19'h00013, 32'h0,        32'h00000012, 1'b0, 3, 1'b0, 32'h0);
    access("sb_13",   1'b1, F3_B,   19'h00013, 32'h00000080, 32'h00000012, 1'b0, 3, 1'b1, 32'h8034AAEF);
    access("lb_13b",  1'b0, F3_B,   19'h00013, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1'b0, 32'h0);
    access("lw_10b",  1'b0, F3_W,   19'h00010, 32'h0,        32'h8034AAEF, 1'b0, 3, 1'b0, 32'h0);

    // A store request held high while a load is in flight must be dropped.
    @(negedge clock);
    we = 1'b0; funct3 = F3_W; addr = 19'h00010; req = 1'b1;
    e.name = "busy_lw"; e.rdata = 32'h8034AAEF; e.err = 1'b0; e.lat = 3; e.issue = cyc;
    exp_q.push_back(e);
    @(negedge clock);
    check32("busy_high", {31'd0, busy}, 32'd1);
    we = 1'b1; funct3 = F3_W; addr = 19'h00020; wdata = 32'h00000055;
    @(negedge clock);
    @(negedge clock);
    req = 1'b0;
    repeat (4) @(negedge clock);

    // Reset while a byte store is reading: nothing may be written.
    we = 1'b1; funct3 = F3_B; addr = 19'h00010; wdata = 32'h00000077; req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    check32("rst_in_read", {31'd0, ramR}, 32'd1);
    nReset = 1'b0;
    #1;
    check32("rst_mid_flags", {27'd0, busy, done, err, ramR, ramW}, 32'd0);
    check32("rst_mid_rdata", rdata, 32'd0);
    check32("rst_mid_addr", {15'd0, ramAddr}, 32'd0);
    check32("rst_mid_wdata", ramDataW, 32'd0);
    repeat (2) @(negedge clock);
    nReset = 1'b1;

    access("lw_after_rst", 1'b0, F3_W, 19'h00010, 32'h0, 32'h8034AAEF, 1'b0, 3, 1'b0, 32'h0);

    repeat (3) @(negedge clock);
    check32("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check32("wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
